// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl -- pipeline stall / flush / redirect controller
//
// Purpose:
//    Converts per-stage stall requests into a backward-propagating hold mask,
//    and turns exception entry / return events into a one-cycle flush pulse
//    with a redirect PC. After each flush, further exception events are masked
//    for FLUSH_HOLD cycles so the refilling pipeline cannot re-trigger.
//
// Parameters:
//    NSTAGE     number of pipeline stages (bit 0 = PC stage)
//    AW         PC / address width
//    FLUSH_HOLD cycles exception events stay masked after a flush (0..15)
//    WDOG_MAX   consecutive-stall limit for the watchdog (1..65535)
//
// Ports:
//    clk           in   rising-edge clock
//    rst           in   synchronous active-high reset
//    stallreq      in   [NSTAGE] bit i = stall request from stage i
//    excp_req      in   exception taken, redirect to excp_vec
//    excp_vec      in   [AW] exception handler address
//    excp_ret      in   exception return, redirect to epc
//    epc           in   [AW] return address
//    stall         out  [NSTAGE] per-stage hold, bit i freezes stage i
//    flush         out  one-cycle flush pulse
//    new_pc        out  [AW] redirect target, valid while flush=1
//    busy          out  controller is in FLUSH or HOLD
//    stall_timeout out  sticky watchdog flag
//
// Configuration:
//    PIPE_CTRL_WDOG_EN  when defined, builds the consecutive-stall watchdog;
//                       otherwise stall_timeout is tied to 0.
// ============================================================================
module pipe_ctrl #(
   parameter int NSTAGE     = 6,
   parameter int AW         = 32,
   parameter int FLUSH_HOLD = 2,
   parameter int WDOG_MAX   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSTAGE-1:0] stallreq,
   input  logic              excp_req,
   input  logic [AW-1:0]     excp_vec,
   input  logic              excp_ret,
   input  logic [AW-1:0]     epc,
   output logic [NSTAGE-1:0] stall,
   output logic              flush,
   output logic [AW-1:0]     new_pc,
   output logic              busy,
   output logic              stall_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

   // Reject parameter values the 4-bit hold counter / 16-bit watchdog
   // counter cannot represent.
   if (FLUSH_HOLD < 0 || FLUSH_HOLD > 15) begin : g_bad_flush_hold
      $error("pipe_ctrl: FLUSH_HOLD out of range 0..15");
   end
   if (WDOG_MAX < 1 || WDOG_MAX > 65535) begin : g_bad_wdog_max
      $error("pipe_ctrl: WDOG_MAX out of range 1..65535");
   end

   state_t            state;
   logic [3:0]        hold_cnt;
   logic [NSTAGE-1:0] stall_mask;

   // A stalled stage must also freeze every younger stage behind it, so the
   // mask is all ones from the highest requesting stage down to stage 0.
   always_comb begin
      logic acc;
      acc        = 1'b0;
      stall_mask = '0;
      for (int i = NSTAGE - 1; i >= 0; i--) begin
         acc           = acc | stallreq[i];
         stall_mask[i] = acc;
      end
   end

   // During a flush every stage is emptied, so holds are meaningless; reset
   // also silences all control outputs immediately.
   always_comb begin
      stall = (rst || state == FLUSH) ? '0 : stall_mask;
      flush = !rst && (state == FLUSH);
      busy  = !rst && (state != IDLE);
   end

   // Controller FSM. Events are only accepted in IDLE; exception entry wins
   // over exception return. The hold counter reaches zero on the same edge
   // that returns to IDLE, which gives HOLD exactly FLUSH_HOLD cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         new_pc   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (excp_req || excp_ret) begin
                  state  <= FLUSH;
                  new_pc <= excp_req ? excp_vec : epc;
               end
            end
            FLUSH: begin
               hold_cnt <= HOLD_INIT;
               if (FLUSH_HOLD == 0) begin
                  state <= IDLE;
               end else begin
                  state <= HOLD;
               end
            end
            HOLD: begin
               hold_cnt <= hold_cnt - 4'd1;
               if (hold_cnt == 4'd1) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PIPE_CTRL_WDOG_EN
   localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_MAX);

   logic [15:0] wdog_cnt;
   logic        timeout_flag;

   // Counts consecutive stalled edges; any unstalled edge restarts the count.
   // The flag latches on the edge the count lands on the limit and only
   // reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdog_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else if (|stall) begin
         if (wdog_cnt != WDOG_LIMIT) begin
            wdog_cnt <= wdog_cnt + 16'd1;
         end
         if (wdog_cnt == WDOG_LIMIT - 16'd1) begin
            timeout_flag <= 1'b1;
         end
      end else begin
         wdog_cnt <= '0;
      end
   end

   assign stall_timeout = timeout_flag;
`else
   assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (NSTAGE=6, AW=32,
// FLUSH_HOLD=2, WDOG_MAX=255)
//
// Purpose:
//    Table of stall-request vectors with hand-computed stall masks, followed
//    by hand-written sequences for exception entry/return, event priority,
//    event masking during HOLD, reset mid-FLUSH / mid-HOLD and the watchdog.
//    Watchdog expectations follow PIPE_CTRL_WDOG_EN.
// ============================================================================
module tb_pipe_ctrl;

   localparam int NSTAGE = 6;
   localparam int AW     = 32;

`ifdef PIPE_CTRL_WDOG_EN
   localparam logic WD_EXP = 1'b1;
`else
   localparam logic WD_EXP = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic [NSTAGE-1:0] stallreq;
   logic              excp_req;
   logic [AW-1:0]     excp_vec;
   logic              excp_ret;
   logic [AW-1:0]     epc;
   logic [NSTAGE-1:0] stall;
   logic              flush;
   logic [AW-1:0]     new_pc;
   logic              busy;
   logic              stall_timeout;

   int checks_total;
   int checks_passed;
   int pulses;

   typedef struct {
      logic [NSTAGE-1:0] req;
      logic [NSTAGE-1:0] exp_stall;
   } stall_vec_t;

   stall_vec_t vecs[8];

   pipe_ctrl #(
      .NSTAGE    (NSTAGE),
      .AW        (AW),
      .FLUSH_HOLD(2),
      .WDOG_MAX  (255)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq     (stallreq),
      .excp_req     (excp_req),
      .excp_vec     (excp_vec),
      .excp_ret     (excp_ret),
      .epc          (epc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .busy         (busy),
      .stall_timeout(stall_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it, away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [NSTAGE-1:0] req, input logic ereq,
                                 input logic eret);
      stallreq = req;
      excp_req = ereq;
      excp_ret = eret;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst      = 1'b1;
      stallreq = '0;
      excp_req = 1'b0;
      excp_ret = 1'b0;
      excp_vec = '0;
      epc      = '0;

      vecs[0] = '{6'b000100, 6'b000111};
      vecs[1] = '{6'b001100, 6'b001111};
      vecs[2] = '{6'b000000, 6'b000000};
      vecs[3] = '{6'b100000, 6'b111111};
      vecs[4] = '{6'b000001, 6'b000001};
      vecs[5] = '{6'b010010, 6'b011111};
      vecs[6] = '{6'b000110, 6'b000111};
      vecs[7] = '{6'b000000, 6'b000000};

      // ---------------- reset state ----------------
      tick();
      tick();
      check_output("rst_flush",   64'(flush),         64'd0);
      check_output("rst_busy",    64'(busy),          64'd0);
      check_output("rst_new_pc",  64'(new_pc),        64'd0);
      check_output("rst_timeout", 64'(stall_timeout), 64'd0);

      // Stall requests and exception events are ignored while in reset.
      excp_vec = 32'h0000_0099;
      apply_stimulus(6'b000100, 1'b1, 1'b0);
      #1;
      check_output("rst_stall_forced", 64'(stall), 64'd0);
      tick();
      rst = 1'b0;
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      #1;
      check_output("rst_event_ignored_flush", 64'(flush),  64'd0);
      check_output("rst_event_ignored_busy",  64'(busy),   64'd0);
      check_output("rst_event_ignored_pc",    64'(new_pc), 64'd0);

      // ---------------- combinational stall mask table ----------------
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].req, 1'b0, 1'b0);
         #1;
         check_output($sformatf("stall_vec%0d", i), 64'(stall), 64'(vecs[i].exp_stall));
      end
      tick();

      // ---------------- exception entry, then HOLD masking ----------------
      excp_vec = 32'h0000_0020;
      apply_stimulus(6'b000000, 1'b1, 1'b0);
      tick();                                   // edge N
      apply_stimulus(6'b000100, 1'b0, 1'b0);
      #1;
      check_output("entry_flush",  64'(flush),  64'd1);
      check_output("entry_pc",     64'(new_pc), 64'h20);
      check_output("entry_stall0", 64'(stall),  64'd0);
      check_output("entry_busy",   64'(busy),   64'd1);
      tick();                                   // cycle N+2
      check_output("hold1_flush", 64'(flush), 64'd0);
      check_output("hold1_busy",  64'(busy),  64'd1);
      check_output("hold1_stall", 64'(stall), 64'b000111);
      epc = 32'h0000_1000;
      apply_stimulus(6'b000000, 1'b0, 1'b1);    // dropped: controller in HOLD
      tick();                                   // cycle N+3
      check_output("hold2_flush", 64'(flush), 64'd0);
      check_output("hold2_busy",  64'(busy),  64'd1);
      tick();                                   // cycle N+4
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      #1;
      check_output("idle_busy",   64'(busy),   64'd0);
      check_output("idle_flush",  64'(flush),  64'd0);
      check_output("held_pc",     64'(new_pc), 64'h20);
      tick();
      check_output("dropped_ret_flush", 64'(flush), 64'd0);
      check_output("dropped_ret_busy",  64'(busy),  64'd0);

      // ---------------- exception return from IDLE ----------------
      epc = 32'h0000_1000;
      apply_stimulus(6'b000000, 1'b0, 1'b1);
      tick();
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      #1;
      check_output("ret_flush", 64'(flush),  64'd1);
      check_output("ret_pc",    64'(new_pc), 64'h1000);
      tick();
      tick();
      tick();
      check_output("ret_done_busy", 64'(busy), 64'd0);

      // ---------------- simultaneous entry and return ----------------
      excp_vec = 32'h0000_0020;
      epc      = 32'h0000_1000;
      apply_stimulus(6'b000000, 1'b1, 1'b1);
      tick();
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      #1;
      check_output("both_pc", 64'(new_pc), 64'h20);
      pulses = int'(flush);
      for (int c = 0; c < 4; c++) begin
         tick();
         pulses += int'(flush);
      end
      check_output("both_one_pulse", 64'(pulses), 64'd1);
      check_output("both_done_busy", 64'(busy),   64'd0);

      // ---------------- reset during FLUSH ----------------
      excp_vec = 32'h0000_0077;
      apply_stimulus(6'b000000, 1'b1, 1'b0);
      tick();
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      #1;
      check_output("pre_rst_flush", 64'(flush), 64'd1);
      rst = 1'b1;
      #1;
      check_output("in_rst_flush", 64'(flush), 64'd0);
      check_output("in_rst_busy",  64'(busy),  64'd0);
      tick();
      rst = 1'b0;
      #1;
      check_output("post_rst_flush", 64'(flush),  64'd0);
      check_output("post_rst_busy",  64'(busy),   64'd0);
      check_output("post_rst_pc",    64'(new_pc), 64'd0);
      tick();
      check_output("post_rst_idle", 64'(busy), 64'd0);

      // ---------------- reset during HOLD ----------------
      excp_vec = 32'h0000_0044;
      apply_stimulus(6'b000000, 1'b1, 1'b0);
      tick();
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      tick();
      check_output("pre_rst_hold_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_output("post_hold_rst_busy", 64'(busy),   64'd0);
      check_output("post_hold_rst_pc",   64'(new_pc), 64'd0);
      tick();
      check_output("post_hold_rst_idle", 64'(busy), 64'd0);

      // ---------------- stall watchdog ----------------
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      tick();
      apply_stimulus(6'b001000, 1'b0, 1'b0);
      for (int c = 0; c < 254; c++) begin
         tick();
      end
      check_output("wdog_254_edges", 64'(stall_timeout), 64'd0);
      tick();
      check_output("wdog_255_edges", 64'(stall_timeout), 64'(WD_EXP));
      apply_stimulus(6'b000000, 1'b0, 1'b0);
      tick();
      tick();
      check_output("wdog_sticky", 64'(stall_timeout), 64'(WD_EXP));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check_output("wdog_rst_clear", 64'(stall_timeout), 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
